// File: rtl/mult_share_arb.sv
// Round-robin sharing of one external 16x16 multiplier among NREQ requesters,
// with a registered-operand stage (S1) and a tagged response stage (S2). Optional checker: MULT_CHECK_EN.
module mult_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic [15:0]        mul_a,
    output logic [15:0]        mul_b,
    input  logic [31:0]        mul_p,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_p,
    output logic               busy,
    output logic [15:0]        err_cnt
);

    logic           s1_v;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW:0]   sum;
    logic           gnt_any;
    logic           adv1;
    logic           adv2;
    logic [15:0]    op_a [NREQ];
    logic [15:0]    op_b [NREQ];

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_v || adv2;
    assign busy = s1_v || rsp_valid;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_a[i] = req_a[16*i +: 16];
            op_b[i] = req_b[16*i +: 16];
        end
    end

    // Search starts at rr_ptr; sum wraps explicitly so non-power-of-two NREQ works.
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_id    = '0;
        sum       = '0;
        if (adv1) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                sum = {1'b0, rr_ptr} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NREQ)) begin
                    sum = sum - (IDW+1)'(NREQ);
                end
                if (!gnt_any && req_valid[sum[IDW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_id  = sum[IDW-1:0];
                end
            end
        end
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign nxt_ptr = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_id     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            if (adv1) begin
                if (gnt_any) begin
                    mul_a  <= op_a[gnt_id];
                    mul_b  <= op_b[gnt_id];
                    s1_id  <= gnt_id;
                    s1_v   <= 1'b1;
                    rr_ptr <= nxt_ptr;
                end else begin
                    s1_v <= 1'b0;
                end
            end
            if (adv2) begin
                rsp_valid <= s1_v;
                if (s1_v) begin
                    rsp_p  <= mul_p;
                    rsp_id <= s1_id;
                end
            end
        end
    end

`ifdef MULT_CHECK_EN
    logic [15:0] chk_a;
    logic [15:0] chk_b;
    logic [31:0] exact;

    assign exact = {16'b0, chk_a} * {16'b0, chk_b};

    // Counts products from the attached multiplier that differ from the exact value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_a   <= '0;
            chk_b   <= '0;
            err_cnt <= '0;
        end else begin
            if (adv1 && gnt_any) begin
                chk_a <= op_a[gnt_id];
                chk_b <= op_b[gnt_id];
            end
            if (adv2 && s1_v && (mul_p != exact) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one combinational 16x16 unsigned multiplier (wallace-style; operands a/b, 32-bit product) among NREQ requesters in the CNN datapath.
- Round-robin arbitration, valid/ready request handshake, operand registering and tagged responses.
- Two-stage pipeline:
  - S1 holds the operands that drive the multiplier.
  - S2 captures the product and presents it to the consumer with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NREQ*16  packed operand A; requester i at bits [16i+15:16i].
- req_b  in  NREQ*16  packed operand B; same packing.
- mul_a  out  16  operand A to the multiplier, registered.
- mul_b  out  16  operand B to the multiplier, registered.
- mul_p  in  32  product from the multiplier; combinational from mul_a/mul_b.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  requester index of the response.
- rsp_p  out  32  product.
- busy  out  1  S1 or S2 occupied.
- err_cnt  out  16  mismatch count (optional feature).

Interface: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): s1_v=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_p=0, err_cnt=0, rr_ptr=0. Outputs stay at these values until the first clk edge after deassertion.
- Stall control:
  - adv2 = !rsp_valid | rsp_ready.
  - adv1 = !s1_v | adv2.
- Arbitration (combinational):
  - Only when adv1=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[i]=1 for the granted i only. If adv1=0 or there are no requests, req_ready=0.
  - req_ready never depends on req_valid of the same requester beyond selection (no combinational loop through consumers).
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] at a rising clk edge.
  - On transfer: mul_a/mul_b <= that requester's operands, s1_id <= i, s1_v <= 1, rr_ptr <= (i+1) mod NREQ.
  - If adv1=1 and no grant: s1_v <= 0.
  - rr_ptr changes only on a transfer.
- S2: when adv2=1:
  - rsp_valid <= s1_v, rsp_p <= mul_p, rsp_id <= s1_id.
  - If s1_v=0, rsp_p/rsp_id hold their previous values.
- Latency:
  - Accepting edge to rsp_valid = 2 edges.
  - Throughput is 1 product/cycle when rsp_ready=1 continuously.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0: S2 holds rsp_p and rsp_id stable.
  - If s1_v=1, S1 also holds, mul_a/mul_b stay stable, and req_ready=0.
  - No product is lost or duplicated.
- Simultaneous events:
  - A response is consumed and a new one loaded in the same edge.
  - A request is accepted into S1 while S1 advances into S2 in the same edge.
- Ordering: responses leave in acceptance order.
- Fairness: a continuously-asserting requester is granted within NREQ accepts.
- busy = s1_v | rsp_valid.
- Reset mid-operation: in-flight S1/S2 contents are discarded. No response appears after reset for pre-reset requests.
- Arithmetic: the product width is 32 bits, unsigned, and is taken unmodified from mul_p. The block performs no arithmetic on the datapath.

Optional Feature:
- Macro MULT_CHECK_EN.
- When defined:
  - Keep copies of the S1 operands.
  - On each S1->S2 advance with s1_v=1, compare mul_p against the exact product mul_a*mul_b (behavioural 32-bit).
  - Increment err_cnt on mismatch, saturating at 16'hFFFF. err_cnt is cleared only by reset.
  - Used to measure approximate-multiplier error rate in silicon.
- When undefined: err_cnt is tied to 0 and no comparison logic is built.

Test Plan:
1. Single request: req_valid[2]=1, a=300, b=7, rsp_ready=1 -> req_ready[2]=1 for one cycle; two edges later rsp_valid=1, rsp_id=2, rsp_p=2100; busy deasserts after the response is consumed.
2. All four requesting continuously, rsp_ready=1, rr_ptr=0 at reset -> grant order 0,1,2,3,0,1; one response per cycle; IDs in the same order.
3. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles with requests pending.
   - Required: rsp_p/rsp_id stable; S1 holds; req_ready=0 after S1 and S2 fill.
   - Release: no lost or duplicated products; values are 65535*65535=32'hFFFE0001 and 0*1234=0.
4. Simultaneous consume and load: rsp_ready toggles 1,0,1 every cycle with requester 1 streaming a=i, b=i+1 -> the response sequence matches i*(i+1) in order with no gaps or repeats.
5. Reset mid-flight: assert rst_n=0 asynchronously between edges while S1/S2 are full -> outputs zero immediately; no response for the pre-reset requests after release; the first post-reset grant goes to requester 0.
6. MULT_CHECK_EN defined: stub multiplier returns exact+1 for 10 products -> err_cnt=10. With an exact multiplier -> err_cnt=0. Macro undefined -> err_cnt=0 always.
